ind_wr_ctrl: RTL

- CPU-to-FPGA write-side peripheral on the asynchronous SRAM-style bus.
- The CPU writes indicator patterns into the block through ncs/nwe cycles.
- The block drives six indicator outputs, steady or blinking, from a prescaled blink phase.
- Sits beside the button/indicator input debouncer on the same bus; it is the output direction of that interface.

---
 rtl/ind_wr_pkg.sv | 24 ++
 rtl/ind_wr_ctrl_if.sv | 17 +
 rtl/ind_wr_ctrl_sync_edge.sv | 27 ++
 rtl/ind_wr_ctrl.sv | 116 +++++++++++
 4 files changed

// File: rtl/ind_wr_pkg.sv
// Shared constants for the indicator write controller: register map,
// indicator count, reset values and the indicator drive equation.
package ind_wr_pkg;

  localparam int IND_N   = 6;
  localparam int STAGE_W = 4;

  localparam logic [1:0] ADDR_ON_LO = 2'd0;
  localparam logic [1:0] ADDR_ON_HI = 2'd1;
  localparam logic [1:0] ADDR_BL_LO = 2'd2;
  localparam logic [1:0] ADDR_BL_HI = 2'd3;

  localparam logic [IND_N-1:0]   IND_RST   = '0;
  localparam logic [STAGE_W-1:0] STAGE_RST = '0;
  localparam logic               SYNC_RST  = 1'b1;

  // A blinking indicator is dark during the active blink phase.
  function automatic logic [IND_N-1:0] ind_drive(input logic [IND_N-1:0] on,
                                                 input logic [IND_N-1:0] bl,
                                                 input logic             phase);
    return on & ~(bl & {IND_N{phase}});
  endfunction

endpackage

// File: rtl/ind_wr_ctrl_if.sv
// CPU-side asynchronous SRAM-style bus control lines (data bus is a plain inout port).
interface ind_wr_ctrl_if #(
  parameter int A = 2
);
  // Bus protocol: ncs/nwe/noe are active-low and asynchronous to clk. A write
  // lasts while ncs and nwe are both low; addr and data must be stable at least
  // 3 clk before the cycle ends and nwe must stay low at least 3 clk. The write
  // commits when either strobe rises. A read (optional build) is ncs and noe low
  // with nwe high.
  logic [A-1:0] addr;
  logic         ncs;
  logic         nwe;
  logic         noe;

  modport master (output addr, output ncs, output nwe, output noe);
  modport slave  (input addr, input ncs, input nwe, input noe);
endinterface

// File: rtl/ind_wr_ctrl_sync_edge.sv
// Two-flop synchronizer with a registered rising-edge strobe that is aligned
// with the cycle in which the synchronized output goes high.
module sync_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic sync,
  output logic rise
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RST_VAL;
      sync <= RST_VAL;
      rise <= 1'b0;
    end else begin
      meta <= d;
      sync <= meta;
      rise <= meta & ~sync;
    end
  end

endmodule

// File: rtl/ind_wr_ctrl.sv
// Indicator write controller: CPU writes staged 6-bit on/blink patterns over the
// async bus; outputs are steady or blinking. Optional readback: IND_READBACK_EN.
module ind_wr_ctrl
  import ind_wr_pkg::*;
#(
  parameter int B         = 3,
  parameter int A         = 2,
  parameter int BLINK_DIV = 12500000,
  parameter int CNT_W     = 24
) (
  input  logic             clk,
  input  logic             reset,
  inout  wire  [B:0]       sram_data,
  ind_wr_ctrl_if.slave     bus,
  output logic [IND_N-1:0] ind,
  output logic             blink_phase
);

  logic ncs_s, nwe_s, ncs_rise, nwe_rise;
  logic wr_act, wr_act_q, commit;

  logic [B:0]         d_cap;
  logic [A-1:0]       a_cap;
  logic [STAGE_W-1:0] stage_on, stage_bl;
  logic [IND_N-1:0]   on_reg, blink_reg;
  logic [CNT_W-1:0]   presc;

  sync_edge #(.RST_VAL(SYNC_RST)) u_ncs_sync (
    .clk(clk), .reset(reset), .d(bus.ncs), .sync(ncs_s), .rise(ncs_rise)
  );

  sync_edge #(.RST_VAL(SYNC_RST)) u_nwe_sync (
    .clk(clk), .reset(reset), .d(bus.nwe), .sync(nwe_s), .rise(nwe_rise)
  );

  assign wr_act = ~ncs_s & ~nwe_s;
  // While wr_act_q is set both synced strobes were low, so any rise ends the write.
  assign commit = wr_act_q & (ncs_rise | nwe_rise);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_act_q <= 1'b0;
      d_cap    <= '0;
      a_cap    <= '0;
    end else begin
      wr_act_q <= wr_act;
      if (wr_act) begin
        d_cap <= sram_data;
        a_cap <= bus.addr;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_on  <= STAGE_RST;
      stage_bl  <= STAGE_RST;
      on_reg    <= IND_RST;
      blink_reg <= IND_RST;
    end else if (commit) begin
      case (a_cap[1:0])
        ADDR_ON_LO: stage_on  <= d_cap[3:0];
        ADDR_ON_HI: on_reg    <= {d_cap[1:0], stage_on};
        ADDR_BL_LO: stage_bl  <= d_cap[3:0];
        ADDR_BL_HI: blink_reg <= {d_cap[1:0], stage_bl};
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc       <= '0;
      blink_phase <= 1'b0;
    end else if (presc == CNT_W'(BLINK_DIV - 1)) begin
      presc       <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      presc <= presc + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ind <= IND_RST;
    else        ind <= ind_drive(on_reg, blink_reg, blink_phase);
  end

`ifdef IND_READBACK_EN
  logic       noe_s, noe_rise, rd_en;
  logic [B:0] rd_data;

  sync_edge #(.RST_VAL(SYNC_RST)) u_noe_sync (
    .clk(clk), .reset(reset), .d(bus.noe), .sync(noe_s), .rise(noe_rise)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_en   <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_en   <= ~ncs_s & ~noe_s & nwe_s & ~noe_rise;
      rd_data <= '0;
      case (bus.addr[1:0])
        ADDR_ON_LO: rd_data[3:0] <= on_reg[3:0];
        ADDR_ON_HI: rd_data[3:0] <= {2'b00, on_reg[5:4]};
        ADDR_BL_LO: rd_data[3:0] <= blink_reg[3:0];
        ADDR_BL_HI: rd_data[3:0] <= {2'b00, blink_reg[5:4]};
      endcase
    end
  end

  assign sram_data = rd_en ? rd_data : 'z;
`else
  // Write-only build: the data bus is only ever sampled, never driven.
`endif

endmodule
